// File: rtl/bp_fe_bht_updater_pkg.sv
// Processor configurations for the BHT updater and the widths each one implies.
package bp_fe_bht_updater_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_small_cfg
    } bp_params_e;

    typedef struct packed {
        int bht_idx_width;
        int bht_offset_width;
        int ghist_width;
        int bht_row_width;
        int bht_row_els;
    } bp_proc_param_s;

    // Each row holds bht_row_els 2-bit counters; offset selects one of them.
    function automatic bp_proc_param_s bp_cfg_f(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_small_cfg: p = '{bht_idx_width: 4, bht_offset_width: 1, ghist_width: 1,
                                  bht_row_width: 4, bht_row_els: 2};
            default:        p = '{bht_idx_width: 7, bht_offset_width: 2, ghist_width: 2,
                                  bht_row_width: 8, bht_row_els: 4};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bp_fe_defines.svh
// Front-end struct declaration macros. The BHT update entry is sized by the
// processor configuration, so it is declared in place by the user module.
`ifndef BP_FE_DEFINES_SVH
`define BP_FE_DEFINES_SVH

`define DECLARE_BP_FE_BHT_ENTRY_S(idx_w, off_w, gh_w, row_w) \
    typedef struct packed {                                  \
        logic [idx_w-1:0] idx;                               \
        logic [off_w-1:0] offset;                            \
        logic [gh_w-1:0]  ghist;                             \
        logic [row_w-1:0] val;                               \
        logic             correct;                           \
    } bp_fe_bht_entry_s

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with flush. The head is read straight out of storage,
// so a freshly written entry is never visible in the cycle it is written.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0] mem_q;
    logic [ptr_w_lp-1:0]           rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]           cnt_q, cnt_d;
    logic                          enq, deq;

    assign ready_o = (cnt_q != cnt_w_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointers wrap naturally since els_p is a power of two; the count tells full from empty.
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
            if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
            cnt_d = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq & ~flush_i & ~reset_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_fe_bht_updater.sv
// Buffers resolved-branch BHT updates, dropping ones that would not change the row,
// and presents them one at a time to the BHT write port.
`include "bp_fe_defines.svh"

module bp_fe_bht_updater
    import bp_fe_bht_updater_pkg::*;
#(
    parameter bp_params_e     bp_params_p        = e_bp_default_cfg,
    parameter int             els_p              = 4,
    localparam bp_proc_param_s cfg_lp            = bp_cfg_f(bp_params_p),
    localparam int            bht_idx_width_p    = cfg_lp.bht_idx_width,
    localparam int            bht_offset_width_p = cfg_lp.bht_offset_width,
    localparam int            ghist_width_p      = cfg_lp.ghist_width,
    localparam int            bht_row_width_p    = cfg_lp.bht_row_width,
    localparam int            bht_row_els_p      = cfg_lp.bht_row_els
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          bht_init_done_i,

    input  logic                          upd_v_i,
    output logic                          upd_ready_o,
    input  logic [bht_idx_width_p-1:0]    upd_idx_i,
    input  logic [bht_offset_width_p-1:0] upd_offset_i,
    input  logic [ghist_width_p-1:0]      upd_ghist_i,
    input  logic [bht_row_width_p-1:0]    upd_val_i,
    input  logic                          upd_correct_i,

    input  logic                          flush_i,

    output logic                          w_v_o,
    output logic [bht_idx_width_p-1:0]    w_idx_o,
    output logic [bht_offset_width_p-1:0] w_offset_o,
    output logic [ghist_width_p-1:0]      w_ghist_o,
    output logic [bht_row_width_p-1:0]    val_o,
    output logic                          correct_o,
    input  logic                          w_yumi_i,

    output logic                          empty_o,
    output logic [15:0]                   filtered_cnt_o
);

    `DECLARE_BP_FE_BHT_ENTRY_S(bht_idx_width_p, bht_offset_width_p, ghist_width_p, bht_row_width_p);

    bp_fe_bht_entry_s             upd_entry, head_entry;
    logic                         fifo_ready, fifo_v;
    logic                         accept, redundant, enq;
    logic [bht_offset_width_p:0]  hi_bit_idx;
    logic [15:0]                  filtered_cnt_q, filtered_cnt_d;

    assign upd_entry = '{idx: upd_idx_i, offset: upd_offset_i, ghist: upd_ghist_i,
                         val: upd_val_i, correct: upd_correct_i};

    // Bit 2*offset is the upper bit of the selected 2-bit counter after the row's
    // per-counter encoding; 0 there with a correct prediction means a saturated counter.
    assign hi_bit_idx  = {upd_offset_i, 1'b0};
    assign redundant   = upd_correct_i & ~upd_val_i[hi_bit_idx];
    assign upd_ready_o = fifo_ready & ~flush_i;
    assign accept      = upd_v_i & upd_ready_o;
    assign enq         = accept & ~redundant;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(bp_fe_bht_entry_s)),
        .els_p   (els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .v_i     (enq),
        .data_i  (upd_entry),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (head_entry),
        .yumi_i  (w_yumi_i & w_v_o)
    );

    assign empty_o    = ~fifo_v;
    assign w_v_o      = fifo_v & bht_init_done_i;
    assign w_idx_o    = head_entry.idx;
    assign w_offset_o = head_entry.offset;
    assign w_ghist_o  = head_entry.ghist;
    assign val_o      = head_entry.val;
    assign correct_o  = head_entry.correct;

    always_comb begin
        filtered_cnt_d = filtered_cnt_q;
        if (accept & redundant & (filtered_cnt_q != 16'hFFFF))
            filtered_cnt_d = filtered_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) filtered_cnt_q <= '0;
        else         filtered_cnt_q <= filtered_cnt_d;
    end

    assign filtered_cnt_o = filtered_cnt_q;

    // The BHT must only consume a request that is actually being offered.
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
                                         !(w_yumi_i && !w_v_o));

endmodule

// File: tb/tb_bp_fe_bht_updater.sv
// Scoreboarded bench for bp_fe_bht_updater in its default configuration.
module tb_bp_fe_bht_updater;

    logic        clk_i = 1'b0;
    logic        reset_i, bht_init_done_i, upd_v_i, upd_ready_o, upd_correct_i, flush_i;
    logic [6:0]  upd_idx_i, w_idx_o;
    logic [1:0]  upd_offset_i, w_offset_o, upd_ghist_i, w_ghist_o;
    logic [7:0]  upd_val_i, val_o;
    logic        w_v_o, correct_o, w_yumi_i, empty_o;
    logic [15:0] filtered_cnt_o;

    always #5 clk_i = ~clk_i;

    bp_fe_bht_updater dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .bht_init_done_i (bht_init_done_i),
        .upd_v_i         (upd_v_i),
        .upd_ready_o     (upd_ready_o),
        .upd_idx_i       (upd_idx_i),
        .upd_offset_i    (upd_offset_i),
        .upd_ghist_i     (upd_ghist_i),
        .upd_val_i       (upd_val_i),
        .upd_correct_i   (upd_correct_i),
        .flush_i         (flush_i),
        .w_v_o           (w_v_o),
        .w_idx_o         (w_idx_o),
        .w_offset_o      (w_offset_o),
        .w_ghist_o       (w_ghist_o),
        .val_o           (val_o),
        .correct_o       (correct_o),
        .w_yumi_i        (w_yumi_i),
        .empty_o         (empty_o),
        .filtered_cnt_o  (filtered_cnt_o)
    );

    int          tests = 0, fails = 0;
    int          cnt_m = 0;
    bit          quiet = 0;
    logic [19:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, check at posedge+2, advance the model.
    task automatic step(input bit v, input logic [6:0] idx, input logic [1:0] off,
                        input logic [1:0] gh, input logic [7:0] val, input bit corr,
                        input bit yumi, input bit fl);
        bit wv_m, rdy_m;
        wv_m  = (sb.size() > 0) && bht_init_done_i;
        rdy_m = (sb.size() < 4) && !fl;
        upd_v_i = v; upd_idx_i = idx; upd_offset_i = off; upd_ghist_i = gh;
        upd_val_i = val; upd_correct_i = corr; w_yumi_i = yumi & wv_m; flush_i = fl;
        #1;
        if (!quiet) begin
            chk("ready", upd_ready_o, rdy_m);
            chk("w_v", w_v_o, wv_m);
            chk("empty", empty_o, sb.size() == 0);
            chk("fcnt", filtered_cnt_o, cnt_m);
            if (sb.size() > 0)
                chk("head", {w_idx_o, w_offset_o, w_ghist_o, val_o, correct_o}, sb[0]);
        end
        if (fl) sb.delete();
        else begin
            if (yumi && wv_m) void'(sb.pop_front());
            if (v && rdy_m) begin
                if (corr && !val[2*off]) begin
                    if (cnt_m < 65535) cnt_m++;
                end else sb.push_back({idx, off, gh, val, corr});
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [6:0] idx);
        step(1, idx, idx[1:0], 2'd1, 8'hA5, 1'b0, 0, 0);
    endtask

    task automatic pop1();
        step(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset(input int n);
        reset_i = 1; upd_v_i = 0; w_yumi_i = 0; flush_i = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk_i); #1; end
        reset_i = 0;
        sb.delete();
        cnt_m = 0;
    endtask

    initial begin
        reset_i = 1; bht_init_done_i = 0; upd_v_i = 0; upd_idx_i = 0; upd_offset_i = 0;
        upd_ghist_i = 0; upd_val_i = 0; upd_correct_i = 0; flush_i = 0; w_yumi_i = 0;
        @(posedge clk_i); #1;
        do_reset(2);
        #1;
        chk("rst_empty", empty_o, 1);
        chk("rst_wv", w_v_o, 0);
        chk("rst_ready", upd_ready_o, 1);
        chk("rst_fcnt", filtered_cnt_o, 0);
        @(posedge clk_i); #1;

        // Writes held back until BHT init completes
        push(7'd10); push(7'd11);
        idle(1);
        chk("noinit_wv", w_v_o, 0);
        bht_init_done_i = 1;
        idle(1);
        chk("init_head", w_idx_o, 10);
        pop1(); pop1(); idle(1);

        // Redundant update dropped
        step(1, 7'h11, 2'd1, 2'd2, 8'b0000_1000, 1'b1, 0, 0);
        idle(1);
        chk("redund_empty", empty_o, 1);
        chk("redund_cnt", filtered_cnt_o, 1);

        // Head held stable under back-pressure, then exactly one pop
        push(7'd20); push(7'd21);
        idle(5);
        chk("hold_head", w_idx_o, 20);
        pop1();
        chk("hold_pop", w_idx_o, 21);
        chk("hold_nonempty", empty_o, 0);
        pop1(); idle(1);

        // Full, pop with concurrent (refused) update, drain in order
        push(7'd1); push(7'd2); push(7'd3); push(7'd4);
        chk("full_ready", upd_ready_o, 0);
        step(1, 7'd99, 2'd0, 2'd0, 8'h01, 1'b0, 1, 0);
        chk("refill_ready", upd_ready_o, 1);
        idle(1);
        push(7'd5);
        for (int i = 2; i <= 5; i++) begin
            chk("drain_order", w_idx_o, i);
            pop1();
        end
        idle(1);

        // Simultaneous enqueue and dequeue keeps occupancy
        push(7'd30); push(7'd31);
        step(1, 7'd32, 2'd2, 2'd3, 8'h10, 1'b0, 1, 0);
        chk("simul_head", w_idx_o, 31);
        pop1(); pop1(); idle(1);

        // Flush beats a concurrent update and a concurrent pop
        push(7'd40); push(7'd41); push(7'd42);
        step(1, 7'd43, 2'd0, 2'd0, 8'h01, 1'b0, 1, 1);
        chk("flush_empty", empty_o, 1);
        chk("flush_wv", w_v_o, 0);
        idle(2);

        // Random mix
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), 7'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

        // Reset mid-operation
        push(7'd50); push(7'd51);
        do_reset(1);
        #1;
        chk("midrst_wv", w_v_o, 0);
        chk("midrst_empty", empty_o, 1);
        chk("midrst_fcnt", filtered_cnt_o, 0);
        @(posedge clk_i); #1;
        idle(2);

        // Saturating filtered counter
        quiet = 1;
        for (int i = 0; i < 65540; i++) step(1, 7'd3, 2'd0, 2'd0, 8'h00, 1'b1, 0, 0);
        quiet = 0;
        idle(1);
        chk("sat_cnt", filtered_cnt_o, 16'hFFFF);
        step(1, 7'd3, 2'd0, 2'd0, 8'h00, 1'b1, 0, 1);
        idle(1);
        chk("sat_flush_cnt", filtered_cnt_o, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
